// File: rtl/wb_queue_pkg.sv
// Shared CPU writeback definitions: register-file geometry and the queued write entry.
package wb_queue_pkg;
    localparam int WB_DW = 16;
    localparam int WB_AW = 3;

    typedef struct packed {
        logic [WB_AW-1:0] idx;
        logic [WB_DW-1:0] dat;
    } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// Combinational youngest-match finder over the occupied window of the writeback ring.
module wb_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]         head,
    input  logic [PW:0]           count,
    input  logic [WB_AW-1:0]      chk_idx,
    output logic                  hit,
    output logic [WB_DW-1:0]      dat
);

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] pos;
        logic          match;
        hit   = 1'b0;
        dat   = '0;
        pos   = '0;
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pos   = head + PW'(i);
            match = ((PW+1)'(i) < count) && (entries[pos].idx == chk_idx);
            hit   = hit | match;
            dat   = match ? entries[pos].dat : dat;
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers results ahead of the register-file write port and forwards queued data.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [AW-1:0]            res_idx,
    input  logic [DW-1:0]            res_dat,
    input  logic                     wr_hold,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_idx,
    output logic [DW-1:0]            wr_dat,
    input  logic [AW-1:0]            chkA_idx,
    input  logic [AW-1:0]            chkB_idx,
    output logic                     fwdA_hit,
    output logic                     fwdB_hit,
    output logic [DW-1:0]            fwdA_dat,
    output logic [DW-1:0]            fwdB_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  push;
    logic                  pop;

    assign res_ready = !rst && (count < (PW+1)'(DEPTH));
    assign wr_en     = (count != '0) && !wr_hold;
    assign push      = res_valid && res_ready;
    assign pop       = wr_en;

    // Present the head entry on the write port; zeros when no write is issued.
    always_comb begin
        if (wr_en) begin
            wr_idx = mem[head].idx;
            wr_dat = mem[head].dat;
        end else begin
            wr_idx = '0;
            wr_dat = '0;
        end
    end

    // Entry storage is qualified by occupancy only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{idx: res_idx, dat: res_dat};
        end
    end

    // Ring pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    wb_match #(.DEPTH(DEPTH), .PW(PW)) u_match_a (
        .entries (mem),
        .head    (head),
        .count   (count),
        .chk_idx (chkA_idx),
        .hit     (fwdA_hit),
        .dat     (fwdA_dat)
    );

    wb_match #(.DEPTH(DEPTH), .PW(PW)) u_match_b (
        .entries (mem),
        .head    (head),
        .count   (count),
        .chk_idx (chkB_idx),
        .hit     (fwdB_hit),
        .dat     (fwdB_dat)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue against a queue-based reference model.
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] dat;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [2:0]  res_idx = 3'd0;
    logic [15:0] res_dat = 16'd0;
    logic        wr_hold = 1'b0;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [15:0] wr_dat;
    logic [2:0]  chkA_idx = 3'd0;
    logic [2:0]  chkB_idx = 3'd0;
    logic        fwdA_hit;
    logic        fwdB_hit;
    logic [15:0] fwdA_dat;
    logic [15:0] fwdB_dat;
    logic [2:0]  count;

    ent_t mq[$];
    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_dat(res_dat),
        .wr_hold(wr_hold), .wr_en(wr_en), .wr_idx(wr_idx), .wr_dat(wr_dat),
        .chkA_idx(chkA_idx), .chkB_idx(chkB_idx),
        .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit), .fwdA_dat(fwdA_dat), .fwdB_dat(fwdB_dat),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [2:0] c, output logic hit, output logic [15:0] dat);
        hit = 1'b0;
        dat = 16'd0;
        foreach (mq[k]) begin
            if (mq[k].idx == c) begin
                hit = 1'b1;
                dat = mq[k].dat;
            end
        end
    endfunction

    // One clock of stimulus: drive, check combinational view against the model, advance the model.
    task automatic step(input logic v, input logic [2:0] i, input logic [15:0] d,
                        input logic h, input logic [2:0] a, input logic [2:0] b);
        logic        exp_wr;
        logic        ha;
        logic        hb;
        logic [15:0] da;
        logic [15:0] db;
        ent_t        e;
        @(negedge clk);
        res_valid = v; res_idx = i; res_dat = d; wr_hold = h; chkA_idx = a; chkB_idx = b;
        #1;
        exp_wr = (mq.size() > 0) && !h;
        lookup(a, ha, da);
        lookup(b, hb, db);
        chk("count", 32'(count), 32'(mq.size()));
        chk("res_ready", 32'(res_ready), 32'(mq.size() < DEPTH));
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        chk("fwdA_hit", 32'(fwdA_hit), 32'(ha));
        chk("fwdA_dat", 32'(fwdA_dat), 32'(da));
        chk("fwdB_hit", 32'(fwdB_hit), 32'(hb));
        chk("fwdB_dat", 32'(fwdB_dat), 32'(db));
        if (v && mq.size() < DEPTH) begin
            e.idx = i;
            e.dat = d;
            mq.push_back(e);
            sb.push_back(e);
        end
        if (exp_wr) begin
            void'(mq.pop_front());
        end
    endtask

    // Write-port monitor: every strobe must match the oldest outstanding accepted result.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (wr_en) begin
                    if (sb.size() == 0) begin
                        chk("wr_unexpected", 32'(wr_en), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_idx", 32'(wr_idx), 32'(e.idx));
                        chk("wr_dat", 32'(wr_dat), 32'(e.dat));
                    end
                end else begin
                    chk("wr_idx_idle", 32'(wr_idx), 32'd0);
                    chk("wr_dat_idle", 32'(wr_dat), 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_res_ready", 32'(res_ready), 32'd0);
        chk("rst_fwdA", 32'({fwdA_hit, fwdA_dat}), 32'd0);
        chk("rst_fwdB", 32'({fwdB_hit, fwdB_dat}), 32'd0);
        chk("rst_wr_dat", 32'({wr_idx, wr_dat}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single result through an empty queue.
        step(1'b1, 3'd2, 16'h1234, 1'b0, 3'd2, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd0);
        chk("single_wr_idx", 32'(wr_idx), 32'd2);
        chk("single_wr_dat", 32'(wr_dat), 32'h1234);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd0);

        // Fill under hold, refuse a fifth, then drain in order.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'(k + 1), 16'(16'hC000 + k), 1'b1, 3'd1, 3'd4);
        end
        step(1'b1, 3'd7, 16'hDEAD, 1'b1, 3'd7, 3'd3);
        chk("full_ready", 32'(res_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd7, 3'd3);
        end

        // Youngest match wins on duplicate indices.
        step(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd3, 3'd5);
        step(1'b1, 3'd3, 16'hBBBB, 1'b1, 3'd3, 3'd5);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5);
        chk("dup_fwdA_dat", 32'(fwdA_dat), 32'hBBBB);
        chk("dup_fwdB_hit", 32'(fwdB_hit), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd5);
        end

        // Steady push+drain at count 2 across pointer wraps.
        step(1'b1, 3'd1, 16'h0101, 1'b1, 3'd1, 3'd2);
        step(1'b1, 3'd2, 16'h0202, 1'b1, 3'd1, 3'd2);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 3'(k), 16'(16'h5000 + k), 1'b0, 3'(k), 3'(k + 1));
            chk("steady_count", 32'(count), 32'd2);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
        end

        // Asynchronous reset mid-cycle with three entries queued.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'(k + 4), 16'(16'h7700 + k), 1'b1, 3'd4, 3'd6);
        end
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 3'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_wr_en", 32'(wr_en), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_fwdA", 32'(fwdA_hit), 32'd0);
        mq.delete();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 3'd6);
        end

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
